// File: rtl/bht_pkg.sv
// Shared definitions for the BHT update controller.
//   state_t   : controller FSM encoding
//   wr_kind_t : BHT write-kind codes carried on wr_kind
//   CNT_*     : 2-bit saturating counter constants
//   cnt_next  : saturating counter step (no wrap at 0 or 3)
package bht_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALLOC  = 3'd1,
    S_UPD_RD = 3'd2,
    S_UPD_WR = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WK_ALLOC = 2'b00,
    WK_CNT   = 2'b01,
    WK_INV   = 2'b10
  } wr_kind_t;

  localparam logic [1:0] CNT_MIN  = 2'b00;
  localparam logic [1:0] CNT_INIT = 2'b01;  // weakly not-taken
  localparam logic [1:0] CNT_MAX  = 2'b11;

  function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == CNT_MAX) ? CNT_MAX : c + 2'd1;
    else       return (c == CNT_MIN) ? CNT_MIN : c - 2'd1;
  endfunction

endpackage

// File: rtl/bht_res_fifo.sv
// Resolution queue: synchronous FIFO of D entries, W bits wide.
//   clr           : discard all entries (wins over push/pop)
//   push/din      : write when asserted (caller guarantees !full)
//   pop/dout      : dout is the head entry; pop advances it
//   full/empty    : occupancy flags
//   count         : occupancy, $clog2(D)+1 bits
module bht_res_fifo #(
  parameter int D = 4,
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic [W-1:0]       din,
  input  logic               pop,
  output logic [W-1:0]       dout,
  output logic               full,
  output logic               empty,
  output logic [$clog2(D):0] count
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D) + 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wptr, rptr;

  // Explicit wrap so non-power-of-two depths still work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dout  = mem[rptr];
  assign full  = (count == CW'(D));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= inc(wptr);
      if (pop)  rptr <= inc(rptr);
      // simultaneous push+pop leaves occupancy unchanged
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr] <= din;
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT update controller: sequences allocation writes, queued counter
// updates (read-modify-write) and whole-table invalidation.
//   alloc_*   : allocation handshake from fetch (idx, pc tag, target)
//   res_*     : branch-resolution handshake (idx, taken), queued
//   flush_req : one-cycle pulse, invalidate all DEPTH entries
//   rd_en/rd_idx, rd_cnt : counter read; rd_cnt valid cycle after rd_en
//   wr_*      : BHT write port (kind 00 alloc, 01 counter, 10 invalidate)
//   busy      : FSM not idle or resolutions pending
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int IDXW   = 3,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  input  logic [IDXW-1:0] alloc_idx,
  input  logic [31:0]     alloc_pc,
  input  logic [31:0]     alloc_tgt,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic [IDXW-1:0] res_idx,
  input  logic            res_taken,
  input  logic            flush_req,
  output logic            rd_en,
  output logic [IDXW-1:0] rd_idx,
  input  logic [1:0]      rd_cnt,
  output logic            wr_en,
  output logic [IDXW-1:0] wr_idx,
  output logic [1:0]      wr_kind,
  output logic [31:0]     wr_pc,
  output logic [31:0]     wr_tgt,
  output logic [1:0]      wr_cnt,
  output logic            busy
);
  state_t state, nxt;

  logic [IDXW-1:0]        a_idx, u_idx, f_idx;
  logic [31:0]            a_pc, a_tgt;
  logic                   u_taken, flush_pend;
  logic                   q_push, q_pop, q_clr, q_full, q_empty;
  logic [IDXW:0]          q_head;
  logic [$clog2(QDEPTH):0] q_count;

  assign alloc_ready = (state == S_IDLE) && !flush_req && !q_full;
  assign res_ready   = !q_full && (state != S_FLUSH);
  assign q_push      = res_valid && res_ready;
  assign busy        = (state != S_IDLE) || (q_count != '0);
  // Queue is discarded on the transition into FLUSH.
  assign q_clr       = (nxt == S_FLUSH) && (state != S_FLUSH);

  bht_res_fifo #(.D(QDEPTH), .W(IDXW + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (q_clr),
    .push  (q_push),
    .din   ({res_idx, res_taken}),
    .pop   (q_pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    nxt     = state;
    q_pop   = 1'b0;
    rd_en   = 1'b0;
    rd_idx  = '0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_kind = WK_ALLOC;
    wr_pc   = '0;
    wr_tgt  = '0;
    wr_cnt  = '0;
    case (state)
      S_IDLE: begin
        if (flush_req) nxt = S_FLUSH;
        else if (q_full) begin
          q_pop = 1'b1;
          nxt   = S_UPD_RD;
        end else if (alloc_valid) nxt = S_ALLOC;  // alloc_ready is high here
        else if (!q_empty) begin
          q_pop = 1'b1;
          nxt   = S_UPD_RD;
        end
      end
      S_ALLOC: begin
        wr_en   = 1'b1;
        wr_idx  = a_idx;
        wr_kind = WK_ALLOC;
        wr_pc   = a_pc;
        wr_tgt  = a_tgt;
        wr_cnt  = CNT_INIT;
        nxt     = flush_req ? S_FLUSH : S_IDLE;
      end
      S_UPD_RD: begin
        rd_en  = 1'b1;
        rd_idx = u_idx;
        nxt    = S_UPD_WR;
      end
      S_UPD_WR: begin
        wr_en   = 1'b1;
        wr_idx  = u_idx;
        wr_kind = WK_CNT;
        wr_cnt  = cnt_next(rd_cnt, u_taken);
        // a flush seen during the read is deferred until this write lands
        nxt     = (flush_req || flush_pend) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        wr_en   = 1'b1;
        wr_idx  = f_idx;
        wr_kind = WK_INV;
        if (f_idx == IDXW'(DEPTH - 1)) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_idx      <= '0;
      a_pc       <= '0;
      a_tgt      <= '0;
      u_idx      <= '0;
      u_taken    <= 1'b0;
      f_idx      <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= nxt;
      if (alloc_valid && alloc_ready) begin
        a_idx <= alloc_idx;
        a_pc  <= alloc_pc;
        a_tgt <= alloc_tgt;
      end
      if (q_pop) {u_idx, u_taken} <= q_head;
      // UPD_RD lasts one cycle, so the pending flag only needs to live into UPD_WR
      flush_pend <= (state == S_UPD_RD) && flush_req;
      f_idx      <= (state == S_FLUSH) ? f_idx + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
module tb_bht_update_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid, alloc_ready;
  logic [2:0]  alloc_idx;
  logic [31:0] alloc_pc, alloc_tgt;
  logic        res_valid, res_ready;
  logic [2:0]  res_idx;
  logic        res_taken, flush_req;
  logic        rd_en;
  logic [2:0]  rd_idx;
  logic [1:0]  rd_cnt;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [1:0]  wr_kind;
  logic [31:0] wr_pc, wr_tgt;
  logic [1:0]  wr_cnt;
  logic        busy;

  int npass = 0, ntot = 0;
  int n_alloc_wr = 0, n_upd_wr = 0, n_inv_wr = 0;

  bht_update_ctrl #(.DEPTH(8), .IDXW(3), .QDEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .alloc_pc(alloc_pc), .alloc_tgt(alloc_tgt),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_taken(res_taken),
    .flush_req(flush_req), .rd_en(rd_en), .rd_idx(rd_idx), .rd_cnt(rd_cnt),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_kind(wr_kind), .wr_pc(wr_pc), .wr_tgt(wr_tgt),
    .wr_cnt(wr_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // write monitor and rd/wr exclusivity, sampled mid-low-phase
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("rd_wr_excl", 32'(rd_en && wr_en), 32'd0);
      if (wr_en) begin
        if (wr_kind == 2'b00) n_alloc_wr++;
        else if (wr_kind == 2'b01) n_upd_wr++;
        else n_inv_wr++;
      end
    end
  end

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  // push one resolution, then follow it through read and counter write
  task automatic resolve(input logic [2:0] idx, input logic tk, input logic [1:0] cin,
                         input logic [1:0] cexp, input string tag);
    int k;
    @(negedge clk);
    res_valid = 1'b1; res_idx = idx; res_taken = tk; rd_cnt = cin;
    cyc();
    res_valid = 1'b0;
    k = 0;
    while (!rd_en && k < 8) begin cyc(); k++; end
    chk({tag, "_rd_lat"}, 32'(k), 32'd1);
    chk({tag, "_rd_idx"}, 32'(rd_idx), 32'(idx));
    cyc();
    chk({tag, "_wr_en"},   32'(wr_en), 32'd1);
    chk({tag, "_wr_kind"}, 32'(wr_kind), 32'd1);
    chk({tag, "_wr_idx"},  32'(wr_idx), 32'(idx));
    chk({tag, "_wr_cnt"},  32'(wr_cnt), 32'(cexp));
    cyc();
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, pushes, u0, a0, i0;
    rst_n = 1'b0; alloc_valid = 0; alloc_idx = 0; alloc_pc = 0; alloc_tgt = 0;
    res_valid = 0; res_idx = 0; res_taken = 0; flush_req = 0; rd_cnt = 0;
    #12;
    // reset state
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_res_ready",   32'(res_ready), 32'd1);
    chk("rst_wr_en",       32'(wr_en), 32'd0);
    chk("rst_rd_en",       32'(rd_en), 32'd0);
    chk("rst_busy",        32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // alloc idx5 pc 0x40 tgt 0x80
    @(negedge clk);
    alloc_valid = 1; alloc_idx = 3'd5; alloc_pc = 32'h40; alloc_tgt = 32'h80;
    #1 chk("al_ready", 32'(alloc_ready), 32'd1);
    cyc();
    alloc_valid = 0;
    chk("al_wr_en",   32'(wr_en), 32'd1);
    chk("al_wr_kind", 32'(wr_kind), 32'd0);
    chk("al_wr_idx",  32'(wr_idx), 32'd5);
    chk("al_wr_cnt",  32'(wr_cnt), 32'd1);
    chk("al_wr_pc",   wr_pc, 32'h40);
    chk("al_wr_tgt",  wr_tgt, 32'h80);
    cyc();
    chk("al_done_wr", 32'(wr_en), 32'd0);
    chk("al_done_busy", 32'(busy), 32'd0);

    // counter updates incl. saturation at both ends
    resolve(3'd2, 1'b1, 2'd3, 2'd3, "sat_hi");
    resolve(3'd2, 1'b0, 2'd0, 2'd0, "sat_lo");
    resolve(3'd6, 1'b1, 2'd1, 2'd2, "inc");
    resolve(3'd1, 1'b0, 2'd2, 2'd1, "dec");

    // fill queue, then alloc must wait for a drain
    u0 = n_upd_wr; a0 = n_alloc_wr; pushes = 0;
    @(negedge clk);
    res_valid = 1; res_taken = 1; rd_cnt = 2'd1; res_idx = 0;
    k = 0;
    #1;
    while (res_ready && k < 20) begin
      pushes++; k++;
      cyc();
      res_idx = res_idx + 3'd1;
    end
    res_valid = 0;
    chk("fill_res_ready", 32'(res_ready), 32'd0);
    chk("fill_alloc_ready", 32'(alloc_ready), 32'd0);
    alloc_valid = 1; alloc_idx = 3'd6; alloc_pc = 32'h100; alloc_tgt = 32'h200;
    i0 = n_upd_wr;
    k = 0;
    while (!alloc_ready && k < 20) begin cyc(); k++; end
    chk("fill_alloc_rises", 32'(alloc_ready), 32'd1);
    chk("fill_drain_first", 32'(n_upd_wr > i0), 32'd1);
    cyc();
    alloc_valid = 0;
    k = 0;
    while (busy && k < 60) begin cyc(); k++; end
    cyc();
    chk("fill_upd_count",   32'(n_upd_wr - u0), 32'(pushes));
    chk("fill_alloc_count", 32'(n_alloc_wr - a0), 32'd1);
    chk("fill_pushes_ge4",  32'(pushes >= 4), 32'd1);

    // flush during UPD_RD: update completes, 8 invalidates, queued entry dropped
    @(negedge clk);
    res_valid = 1; res_idx = 3'd4; res_taken = 1; rd_cnt = 2'd2;
    cyc();
    res_valid = 0;
    k = 0;
    while (!rd_en && k < 8) begin cyc(); k++; end
    chk("fl_rd_seen", 32'(rd_en), 32'd1);
    flush_req = 1; res_valid = 1; res_idx = 3'd7; res_taken = 0;
    cyc();
    flush_req = 0; res_valid = 0;
    chk("fl_upd_wr_en",   32'(wr_en), 32'd1);
    chk("fl_upd_wr_kind", 32'(wr_kind), 32'd1);
    chk("fl_upd_wr_cnt",  32'(wr_cnt), 32'd3);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("fl_inv_en",   32'(wr_en), 32'd1);
      chk("fl_inv_kind", 32'(wr_kind), 32'd2);
      chk("fl_inv_idx",  32'(wr_idx), 32'(i));
    end
    u0 = n_upd_wr;
    cyc();
    chk("fl_after_wr", 32'(wr_en), 32'd0);
    chk("fl_after_busy", 32'(busy), 32'd0);
    repeat (4) cyc();
    chk("fl_queue_dropped", 32'(n_upd_wr - u0), 32'd0);

    // reset in the middle of a flush
    @(negedge clk); flush_req = 1;
    cyc(); flush_req = 0;
    k = 0;
    while (!(wr_en && wr_kind == 2'b10 && wr_idx == 3'd3) && k < 12) begin cyc(); k++; end
    chk("rf_at_idx3", 32'(wr_idx), 32'd3);
    i0 = n_inv_wr;
    rst_n = 0;
    #1;
    chk("rf_wr_en",   32'(wr_en), 32'd0);
    chk("rf_wr_idx",  32'(wr_idx), 32'd0);
    chk("rf_wr_kind", 32'(wr_kind), 32'd0);
    chk("rf_busy",    32'(busy), 32'd0);
    chk("rf_res_rdy", 32'(res_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (5) cyc();
    chk("rf_no_more_inv", 32'(n_inv_wr - i0), 32'd0);
    chk("rf_idle_busy", 32'(busy), 32'd0);
    chk("rf_alloc_rdy", 32'(alloc_ready), 32'd1);

    // post-reset function still intact
    resolve(3'd3, 1'b1, 2'd0, 2'd1, "post");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
